// File: rtl/ahb_arb_dec.sv
// AHB arbiter (round-robin, lock, split masking) plus SRAM/default address decoder.
// Define AHB_ARB_FIXED_PRIO_EN to use fixed priority instead of round-robin.
module ahb_arb_dec #(
  parameter int                    NO_OF_MASTERS  = 4,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] SRAM_BASE      = '0,
  parameter int                    SRAM_SIZE_LOG2 = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  input  logic                             HREADY,
  input  logic [1:0]                       HRESP,
  input  logic [NO_OF_MASTERS-1:0]         HBUSREQ,
  input  logic [NO_OF_MASTERS-1:0]         HLOCK,
  input  logic [NO_OF_MASTERS-1:0]         HSPLIT,
  output logic [NO_OF_MASTERS-1:0]         HGRANT,
  output logic [$clog2(NO_OF_MASTERS)-1:0] HMASTER,
  output logic                             HMASTLOCK,
  output logic                             HSEL_SRAM,
  output logic                             HSEL_DEFAULT
);

  localparam int          MW = $clog2(NO_OF_MASTERS);
  localparam int unsigned NM = NO_OF_MASTERS;

  logic [NO_OF_MASTERS-1:0] split_mask;
  logic [NO_OF_MASTERS-1:0] split_set;
  logic [NO_OF_MASTERS-1:0] elig;
  logic [MW-1:0]            grant_idx;
  logic [MW-1:0]            next_idx;
  logic                     found;
  logic                     sram_hit;
  logic                     owner_lock;
  logic                     idle_release;
  logic                     lock_hold;
  logic                     rearb;
`ifndef AHB_ARB_FIXED_PRIO_EN
  logic [MW-1:0]            rr_ptr;
  int unsigned              cand;
`endif

  always_comb begin
    sram_hit     = (HADDR[ADDR_WIDTH-1:SRAM_SIZE_LOG2] == SRAM_BASE[ADDR_WIDTH-1:SRAM_SIZE_LOG2]);
    HSEL_SRAM    = !HRESET && sram_hit;
    HSEL_DEFAULT = !HRESET && !sram_hit;
  end

  always_comb begin
    elig     = HBUSREQ & ~split_mask;
    found    = 1'b0;
    next_idx = '0;
`ifdef AHB_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NM; i++) begin
      if (!found && elig[i[MW-1:0]]) begin
        found    = 1'b1;
        next_idx = i[MW-1:0];
      end
    end
`else
    cand = 0;
    // Scan starts one past the last winner so every requester gets a turn.
    for (int unsigned k = 1; k <= NM; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NM) cand = cand - NM;
      if (!found && elig[cand[MW-1:0]]) begin
        found    = 1'b1;
        next_idx = cand[MW-1:0];
      end
    end
`endif
  end

  always_comb begin
    owner_lock   = HLOCK[grant_idx];
    // An IDLE owner that has dropped HLOCK gives up the bus without the extra lock cycle.
    idle_release = (HTRANS == 2'b00) && !owner_lock;
    lock_hold    = (HMASTLOCK || owner_lock) && !idle_release;
    rearb        = HREADY && (split_mask[grant_idx] || !lock_hold);
    split_set    = '0;
    if (HRESP == 2'b11 && !HREADY) split_set[HMASTER] = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANT     <= NO_OF_MASTERS'(1);
      grant_idx  <= '0;
      HMASTER    <= '0;
      HMASTLOCK  <= 1'b0;
      split_mask <= '0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      rr_ptr     <= '0;
`endif
    end else begin
      split_mask <= (split_mask | split_set) & ~HSPLIT;
      if (HREADY) begin
        HMASTER   <= grant_idx;
        HMASTLOCK <= owner_lock;
      end
      if (rearb) begin
        if (found) begin
          HGRANT    <= NO_OF_MASTERS'(1) << next_idx;
          grant_idx <= next_idx;
`ifndef AHB_ARB_FIXED_PRIO_EN
          rr_ptr    <= next_idx;
`endif
        end else begin
          HGRANT    <= NO_OF_MASTERS'(1);
          grant_idx <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_arb_dec.sv
// Directed bench for ahb_arb_dec (default round-robin build, 4 masters).
module tb_ahb_arb_dec;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [3:0]  HBUSREQ;
  logic [3:0]  HLOCK;
  logic [3:0]  HSPLIT;
  logic [3:0]  HGRANT;
  logic [1:0]  HMASTER;
  logic        HMASTLOCK;
  logic        HSEL_SRAM;
  logic        HSEL_DEFAULT;

  int n_assert = 0;
  int n_fail   = 0;

  ahb_arb_dec #(
    .NO_OF_MASTERS (4),
    .ADDR_WIDTH    (32),
    .SRAM_BASE     (32'h0000_0000),
    .SRAM_SIZE_LOG2(16)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HBUSREQ     (HBUSREQ),
    .HLOCK       (HLOCK),
    .HSPLIT      (HSPLIT),
    .HGRANT      (HGRANT),
    .HMASTER     (HMASTER),
    .HMASTLOCK   (HMASTLOCK),
    .HSEL_SRAM   (HSEL_SRAM),
    .HSEL_DEFAULT(HSEL_DEFAULT)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET = 1'b1; HADDR = '0; HTRANS = 2'd2; HREADY = 1'b1; HRESP = 2'd0;
    HBUSREQ = 4'b1111; HLOCK = '0; HSPLIT = '0;

    tick(); tick();
    check("rst_grant", 32'(HGRANT), 32'h1);
    check("rst_master", 32'(HMASTER), 32'h0);
    check("rst_mlock", 32'(HMASTLOCK), 32'h0);
    check("rst_sel_sram", 32'(HSEL_SRAM), 32'h0);
    check("rst_sel_def", 32'(HSEL_DEFAULT), 32'h0);

    HRESET = 1'b0;
    HADDR = 32'h0000_FFFC; #1;
    check("dec_top_sram", 32'(HSEL_SRAM), 32'h1);
    check("dec_top_def", 32'(HSEL_DEFAULT), 32'h0);
    HADDR = 32'h0001_0000; #1;
    check("dec_above_sram", 32'(HSEL_SRAM), 32'h0);
    check("dec_above_def", 32'(HSEL_DEFAULT), 32'h1);

    // Round-robin with all four requesting
    tick(); check("rr1_grant", 32'(HGRANT), 32'h2); check("rr1_master", 32'(HMASTER), 32'h0);
    tick(); check("rr2_grant", 32'(HGRANT), 32'h4); check("rr2_master", 32'(HMASTER), 32'h1);
    tick(); check("rr3_grant", 32'(HGRANT), 32'h8); check("rr3_master", 32'(HMASTER), 32'h2);
    tick(); check("rr4_grant", 32'(HGRANT), 32'h1); check("rr4_master", 32'(HMASTER), 32'h3);

    // Wait states freeze grant and owner
    HREADY = 1'b0;
    HBUSREQ = 4'b0010; tick(); check("ws1_grant", 32'(HGRANT), 32'h1); check("ws1_master", 32'(HMASTER), 32'h3);
    HBUSREQ = 4'b0100; tick(); check("ws2_grant", 32'(HGRANT), 32'h1); check("ws2_master", 32'(HMASTER), 32'h3);
    HBUSREQ = 4'b1000; tick(); check("ws3_grant", 32'(HGRANT), 32'h1); check("ws3_master", 32'(HMASTER), 32'h3);
    HREADY = 1'b1;
    tick(); check("ws_end_grant", 32'(HGRANT), 32'h8); check("ws_end_master", 32'(HMASTER), 32'h0);

    // Locked burst by master 2 while master 1 waits
    HBUSREQ = 4'b0100; HLOCK = 4'b0100;
    tick(); check("lk_grant0", 32'(HGRANT), 32'h4);
    HBUSREQ = 4'b0110;
    tick(); check("lk_grantA", 32'(HGRANT), 32'h4); check("lk_mlockA", 32'(HMASTLOCK), 32'h1);
    check("lk_masterA", 32'(HMASTER), 32'h2);
    tick(); check("lk_grantB", 32'(HGRANT), 32'h4); check("lk_mlockB", 32'(HMASTLOCK), 32'h1);
    tick(); check("lk_grantC", 32'(HGRANT), 32'h4); check("lk_mlockC", 32'(HMASTLOCK), 32'h1);
    HLOCK = 4'b0000;
    tick(); check("lk_grantD", 32'(HGRANT), 32'h4); check("lk_mlockD", 32'(HMASTLOCK), 32'h0);
    tick(); check("lk_release", 32'(HGRANT), 32'h2);

    // Split: master 1 masked until its HSPLIT pulse
    HBUSREQ = 4'b0010;
    tick(); check("sp_master", 32'(HMASTER), 32'h1); check("sp_grant", 32'(HGRANT), 32'h2);
    HRESP = 2'd3; HREADY = 1'b0;
    tick(); check("sp_hold", 32'(HGRANT), 32'h2);
    HRESP = 2'd0; HREADY = 1'b1;
    tick(); check("sp_regrant", 32'(HGRANT), 32'h1);
    tick(); check("sp_masked", 32'(HGRANT), 32'h1); check("sp_master0", 32'(HMASTER), 32'h0);
    HSPLIT = 4'b0010;
    tick(); check("sp_clr_edge", 32'(HGRANT), 32'h1);
    HSPLIT = 4'b0000;
    tick(); check("sp_resume", 32'(HGRANT), 32'h2);

    // Coincident split set and clear: clear wins
    tick(); check("sc_master", 32'(HMASTER), 32'h1);
    HRESP = 2'd3; HREADY = 1'b0; HSPLIT = 4'b0010;
    tick();
    HRESP = 2'd0; HREADY = 1'b1; HSPLIT = 4'b0000;
    tick(); check("sc_grant", 32'(HGRANT), 32'h2);

    // Locked owner going IDLE releases without the extra cycle
    HBUSREQ = 4'b1000; HLOCK = 4'b0010;
    tick(); check("idl_grant", 32'(HGRANT), 32'h2); check("idl_mlock", 32'(HMASTLOCK), 32'h1);
    HLOCK = 4'b0000; HTRANS = 2'd0;
    tick(); check("idl_release", 32'(HGRANT), 32'h8);

    HADDR = 32'hFFFF_0000; #1;
    check("dec_high_def", 32'(HSEL_DEFAULT), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_arb_dec.md
Name: ahb_arb_dec

Overview:
- Central AHB bus-control block: combined arbiter and address decoder.
- Arbitrates among NO_OF_MASTERS masters using HBUSREQ/HLOCK/HSPLIT, and drives HGRANT, HMASTER and HMASTLOCK.
- Decodes HADDR into the slave selects HSEL_SRAM and HSEL_DEFAULT.
- Sits beside the master drivers and the SRAM/default slaves on the shared AHB interface. It provides the arbiter and decoder roles of that interface.

Parameters:
- NO_OF_MASTERS, 4, number of requesting masters (2..16).
- ADDR_WIDTH, 32, HADDR width.
- SRAM_BASE, 32'h0000_0000, SRAM region base address; aligned to 2**SRAM_SIZE_LOG2.
- SRAM_SIZE_LOG2, 16, log2 of SRAM region size in bytes (64 KB).

Ports:
- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HADDR  in  ADDR_WIDTH  current address-phase address.
- HTRANS  in  2  transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- HREADY  in  1  bus ready; transfer phases advance when 1.
- HRESP  in  2  slave response (0 OKAY, 1 ERROR, 2 RETRY, 3 SPLIT).
- HBUSREQ  in  NO_OF_MASTERS  per-master bus request.
- HLOCK  in  NO_OF_MASTERS  per-master locked-transfer request.
- HSPLIT  in  NO_OF_MASTERS  per-master split-resume pulse from slaves.
- HGRANT  out  NO_OF_MASTERS  one-hot grant, registered.
- HMASTER  out  $clog2(NO_OF_MASTERS)  address-phase owner, registered.
- HMASTLOCK  out  1  current address phase is locked, registered.
- HSEL_SRAM  out  1  SRAM slave select, combinational.
- HSEL_DEFAULT  out  1  default slave select, combinational.

Behaviour:
- Reset (HRESET=1 at HCLK edge):
  - HGRANT = 1 (master 0, default master); HMASTER = 0; HMASTLOCK = 0.
  - Split mask cleared; round-robin pointer = 0.
  - While HRESET=1, HSEL_SRAM = HSEL_DEFAULT = 0.
- Decoder (combinational, out of reset):
  - HSEL_SRAM = 1 iff HADDR[ADDR_WIDTH-1:SRAM_SIZE_LOG2] == SRAM_BASE[ADDR_WIDTH-1:SRAM_SIZE_LOG2]; HSEL_DEFAULT = !HSEL_SRAM.
  - Exactly one select is high. HTRANS does not gate the selects; slaves handle IDLE/BUSY.
- Eligibility: master i is eligible when HBUSREQ[i]=1 and split_mask[i]=0.
- Re-arbitration point: a cycle with HREADY=1 and HMASTLOCK=0 and HLOCK[owner]=0, where owner = index of the current HGRANT bit. At that point, next HGRANT is chosen as:
  - If any master is eligible: the first eligible index scanning from rr_ptr+1 upward, wrapping modulo NO_OF_MASTERS. rr_ptr then becomes that index.
  - If none is eligible: master 0 (default master). rr_ptr is unchanged.
  - If a master whose split_mask bit is set is the only requester, master 0 is granted.
- Lock hold: while HLOCK[owner]=1 or HMASTLOCK=1, HGRANT holds. This keeps the grant through the last locked transfer. The lock is released one HREADY cycle after HLOCK[owner] drops.
- Ownership handover:
  - On every HREADY=1 edge: HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)].
  - When HREADY=0, HMASTER and HMASTLOCK hold.
  - Latency: request to HGRANT is 1 cycle; HGRANT to HMASTER is 1 HREADY cycle.
- Split handling:
  - Split-mask set condition: HRESP==SPLIT and HREADY==0 (first response cycle). This sets split_mask[HMASTER].
  - A masked master cannot be granted. If it currently holds HGRANT, the grant is re-arbitrated at the next HREADY=1 cycle, ignoring its lock.
  - HSPLIT[i]=1 clears split_mask[i] on the same edge.
  - If set and clear for the same bit coincide, the clear wins.
- HTRANS is used only for lock release: a locked owner driving HTRANS=IDLE with HLOCK=0 releases at that HREADY cycle.
- All outputs are X-free after the first reset edge.

Optional Feature:
- AHB_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest eligible index wins; rr_ptr is unused.
  - Undefined (default): round-robin as specified above.
  - Lock, split and default-master rules are identical in both modes.

Test Plan:
- Reset: hold HRESET=1 for 2 cycles with HBUSREQ=4'b1111 -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0, both HSEL=0.
- Decode: HADDR=32'h0000_FFFC -> HSEL_SRAM=1, HSEL_DEFAULT=0; HADDR=32'h0001_0000 -> HSEL_SRAM=0, HSEL_DEFAULT=1.
- Round-robin:
  - Stimulus: HBUSREQ=4'b1111, HREADY=1 constant.
  - Response: HGRANT cycles 0010, 0100, 1000, 0001; HMASTER follows one cycle later.
  - With AHB_ARB_FIXED_PRIO_EN: HGRANT stays 0001.
- Wait states: HREADY=0 for 3 cycles while HBUSREQ changes -> HGRANT and HMASTER frozen; they update on the first HREADY=1 edge.
- Lock:
  - Stimulus: master 2 granted with HLOCK[2]=1 for 4 cycles, HBUSREQ[1]=1.
  - Response: HGRANT stays 0100, HMASTLOCK=1 during those cycles; master 1 is granted only after HLOCK[2] falls and one further HREADY cycle elapses.
- Split:
  - Stimulus: HMASTER=1, HRESP=SPLIT with HREADY=0, then HREADY=1.
  - Response: master 1 is not granted despite HBUSREQ[1]=1.
  - Then: HSPLIT[1] pulse -> master 1 is granted at the next re-arbitration point.
